// File: rtl/regfile_port_arbiter.sv
// Owns the single access port of a small register file: clears every entry after
// reset, then grants one read or write per cycle to NREQ requesters in round-robin order.
module regfile_port_arbiter #(
  parameter int               NREQ      = 2,
  parameter int               WIDTH     = 16,
  parameter int               AW        = 1,
  parameter int               IDW       = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_write,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_addr,
  output logic [WIDTH-1:0]      rf_wdata,
  input  logic [WIDTH-1:0]      rf_rdata,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [AW-1:0]    clr_cnt;
  logic [IDW-1:0]   ptr;

  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             sel_write;
  logic             run_grant;
  logic             run_read;

  // State register.
  // NOTE: clocked processes use non-blocking (<=) so every flop samples pre-edge values;
  // combinational processes use blocking (=) so later statements see earlier results.
  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

  // Next-state logic: the sweep ends on the last address, RUN is held until reset.
  // NOTE: every always_comb assigns a default first so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (clr_cnt == LAST_ADDR) state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  // Round-robin search: first pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1
  // (anything at or above ptr was already rejected by the first pass).
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (IDW'(i) >= ptr)) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
      end
    end
  end

  // Select the granted requester's address, data and direction.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*WIDTH +: WIDTH];
        sel_write = req_write[i];
      end
    end
  end

  assign run_grant = (state == S_RUN) && grant_found;
  assign run_read  = run_grant && !sel_write;

  // Output logic: the sweep owns the port in INIT, the granted requester in RUN.
  always_comb begin
    req_ready = '0;
    rf_we     = 1'b0;
    rf_addr   = '0;
    rf_wdata  = '0;
    case (state)
      S_INIT: begin
        rf_we    = 1'b1;
        rf_addr  = clr_cnt;
        rf_wdata = CLEAR_VAL;
      end
      S_RUN: begin
        if (grant_found) begin
          for (int i = 0; i < NREQ; i++) req_ready[i] = (grant_id == IDW'(i));
          rf_we    = sel_write;
          rf_addr  = sel_addr;
          rf_wdata = sel_wdata;
        end
      end
      default: ;
    endcase
  end

  // Sweep counter, arbitration pointer and the registered read response.
  // NOTE: the register file behind the port has no reset of its own; the INIT sweep
  // is what brings every entry to CLEAR_VAL, so only control and response flops reset here.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt   <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      init_done <= 1'b0;
    end else begin
      if (state == S_INIT) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) init_done <= 1'b1;
      end
      if (run_grant) ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      rsp_valid <= run_read;
      if (run_read) begin
        rsp_id   <= grant_id;
        rsp_data <= rf_rdata;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter (NREQ=2, WIDTH=16, AW=1): reset sweep,
// round-robin table vectors with a read-response scoreboard, and reset corner cases.
module tb_regfile_port_arbiter;

  localparam int              NREQ  = 2;
  localparam int              WIDTH = 16;
  localparam int              AW    = 1;
  localparam int              IDW   = 1;
  localparam int              DEPTH = 2;
  localparam logic [WIDTH-1:0] CLEAR = 16'h0000;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_write = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ*WIDTH-1:0] req_wdata = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rf_we;
  logic [AW-1:0]         rf_addr;
  logic [WIDTH-1:0]      rf_wdata;
  logic [WIDTH-1:0]      rf_rdata;
  logic                  init_done;

  regfile_port_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .AW(AW), .IDW(IDW), .CLEAR_VAL(CLEAR)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Register file behind the port: synchronous write, combinational read.
  logic [WIDTH-1:0] rf_mem [DEPTH];
  always_ff @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_addr];

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic        a0;
    logic        a1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  exp_ready;
    logic        exp_we;
    logic        exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] data;
  } rsp_t;

  vec_t        vecs [16];
  rsp_t        exp_q [$];
  logic [15:0] shadow [DEPTH];
  logic        last_id;
  logic [15:0] last_data;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] v, input logic [1:0] w,
                       input logic a0, input logic a1, input logic [15:0] d0,
                       input logic [15:0] d1);
    @(negedge clk);
    reset     = rst;
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
  endtask

  // A response is due exactly when a read was granted in the previous step.
  task automatic check_rsp();
    rsp_t e;
    logic exp_v;
    exp_v = (exp_q.size() != 0);
    check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      e         = exp_q.pop_front();
      last_id   = e.id;
      last_data = e.data;
    end
    check("rsp_id", 32'(rsp_id), 32'(last_id));
    check("rsp_data", 32'(rsp_data), 32'(last_data));
  endtask

  task automatic sb_reset();
    exp_q.delete();
    last_id   = 1'b0;
    last_data = '0;
    for (int k = 0; k < DEPTH; k++) shadow[k] = CLEAR;
  endtask

  task automatic check_port(input string tag, input logic [1:0] rdy, input logic we,
                            input logic addr, input logic [15:0] wdata, input logic done);
    check({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    check({tag, ".rf_we"}, 32'(rf_we), 32'(we));
    check({tag, ".rf_addr"}, 32'(rf_addr), 32'(addr));
    check({tag, ".rf_wdata"}, 32'(rf_wdata), 32'(wdata));
    check({tag, ".init_done"}, 32'(init_done), 32'(done));
  endtask

  initial begin
    // valid  write  a0    a1    d0        d1        ready  we    addr  wdata
    vecs[0]  = '{2'b11, 2'b11, 1'b0, 1'b1, 16'h1111, 16'h2222, 2'b01, 1'b1, 1'b0, 16'h1111};
    vecs[1]  = '{2'b11, 2'b11, 1'b0, 1'b1, 16'h1111, 16'h2222, 2'b10, 1'b1, 1'b1, 16'h2222};
    vecs[2]  = '{2'b11, 2'b11, 1'b0, 1'b1, 16'h1111, 16'h2222, 2'b01, 1'b1, 1'b0, 16'h1111};
    vecs[3]  = '{2'b11, 2'b11, 1'b0, 1'b1, 16'h1111, 16'h2222, 2'b10, 1'b1, 1'b1, 16'h2222};
    vecs[4]  = '{2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 2'b10, 1'b0, 1'b0, 16'hBEEF};
    vecs[5]  = '{2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 2'b10, 1'b0, 1'b0, 16'hBEEF};
    vecs[6]  = '{2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 2'b10, 1'b0, 1'b0, 16'hBEEF};
    vecs[7]  = '{2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 2'b10, 1'b0, 1'b0, 16'hBEEF};
    vecs[8]  = '{2'b11, 2'b01, 1'b1, 1'b1, 16'h5A5A, 16'h0000, 2'b01, 1'b1, 1'b1, 16'h5A5A};
    vecs[9]  = '{2'b10, 2'b00, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'b10, 1'b0, 1'b1, 16'h0000};
    vecs[10] = '{2'b00, 2'b00, 1'b1, 1'b1, 16'h1234, 16'h4321, 2'b00, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{2'b01, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'b01, 1'b0, 1'b1, 16'h0000};
    vecs[12] = '{2'b01, 2'b01, 1'b0, 1'b0, 16'h7777, 16'h0000, 2'b01, 1'b1, 1'b0, 16'h7777};
    vecs[13] = '{2'b11, 2'b00, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'b10, 1'b0, 1'b1, 16'h0000};
    vecs[14] = '{2'b11, 2'b00, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'b01, 1'b0, 1'b0, 16'h0000};
    vecs[15] = '{2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000};

    // Reset state, with requests already presented.
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    sb_reset();
    drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 16'h1111, 16'h2222);
    check_rsp();
    check_port("reset", 2'b00, 1'b1, 1'b0, CLEAR, 1'b0);

    // Sweep: addr 0 then addr 1, requests held but never granted.
    drive(1'b0, 2'b11, 2'b11, 1'b0, 1'b1, 16'h1111, 16'h2222);
    check_rsp();
    check_port("sweep0", 2'b00, 1'b1, 1'b0, CLEAR, 1'b0);
    drive(1'b0, 2'b11, 2'b11, 1'b0, 1'b1, 16'h1111, 16'h2222);
    check_rsp();
    check_port("sweep1", 2'b00, 1'b1, 1'b1, CLEAR, 1'b0);

    // RUN table: contention, single requester, read-after-write, wrap, back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      logic        g;
      logic        ga;
      logic [15:0] gd;
      drive(1'b0, vecs[i].valid, vecs[i].write, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      check_rsp();
      check_port($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_we,
                 vecs[i].exp_addr, vecs[i].exp_wdata, 1'b1);
      if (vecs[i].exp_ready != 2'b00) begin
        g  = vecs[i].exp_ready[1];
        ga = g ? vecs[i].a1 : vecs[i].a0;
        gd = g ? vecs[i].d1 : vecs[i].d0;
        if (vecs[i].write[g]) shadow[ga] = gd;
        else exp_q.push_back('{id: g, data: shadow[ga]});
      end
    end

    // Mid-sweep reset: reset on the second INIT cycle restarts the sweep at addr 0.
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    check_rsp();
    check_port("pre_reset", 2'b00, 1'b0, 1'b0, 16'h0, 1'b1);
    sb_reset();
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    check_rsp();
    check_port("ms_init0", 2'b00, 1'b1, 1'b0, CLEAR, 1'b0);
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    check_port("ms_init1", 2'b00, 1'b1, 1'b1, CLEAR, 1'b0);
    sb_reset();
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    check_rsp();
    check_port("ms_restart0", 2'b00, 1'b1, 1'b0, CLEAR, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    check_port("ms_restart1", 2'b00, 1'b1, 1'b1, CLEAR, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    check_port("ms_done", 2'b00, 1'b0, 1'b0, 16'h0, 1'b1);

    // Read-then-reset: the pending response is dropped and the sweep restarts.
    drive(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    check_rsp();
    check_port("rr_grant", 2'b01, 1'b0, 1'b0, 16'h0, 1'b1);
    exp_q.push_back('{id: 1'b0, data: shadow[0]});
    sb_reset();
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    check_rsp();
    check_port("rr_init0", 2'b00, 1'b1, 1'b0, CLEAR, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    check_port("rr_init1", 2'b00, 1'b1, 1'b1, CLEAR, 1'b0);

    // After the restarted sweep, req1 reads the cleared addr 1.
    drive(1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 16'h0, 16'h0);
    check_rsp();
    check_port("rr_run", 2'b10, 1'b0, 1'b1, 16'h0, 1'b1);
    exp_q.push_back('{id: 1'b1, data: shadow[1]});
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    check_rsp();
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    check_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
